mtsp_sf_wb_collector: RTL and testbench
=======================================

Name: mtsp_sf_wb_collector

Overview:
- Writeback collector directly downstream of the special-function reciprocal unit.
- Captures per-phase results (PHASE_EN / DOUT), pairs each with the destination tag recorded at issue, and hands results to the register-file write port over a valid/ready handshake.
- The SF pipeline has fixed latency and cannot stall, so the block grants per-phase issue credits that guarantee every in-flight result has a slot.

Parameters:
- DEPTH, 4, entries per phase (power of 2, ≥2); max outstanding ops per phase.
- TAG_W, 6, destination register tag width.

Ports:
- CLK  in  1  main clock
- RST  in  1  reset; synchronous, active-high
- ISSUE_EN  in  2  bit p = SF op issued on phase p this cycle
- ISSUE_TAG0  in  TAG_W  destination tag, phase 0
- ISSUE_TAG1  in  TAG_W  destination tag, phase 1
- ISSUE_READY  out  2  bit p = phase p may issue
- PHASE_EN  in  2  result strobe from SF unit (one-hot or zero)
- DIN  in  32  SF result: {8'b0, sign, exp[6:0] bias 63, frac[15:0]}
- WB_VALID  out  1  writeback request
- WB_READY  in  1  register file accepts
- WB_PHASE  out  1  phase of the presented result
- WB_TAG  out  TAG_W  destination tag
- WB_DATA  out  32  result data
- ERR  out  1  sticky protocol error

Behaviour:
- Per phase p: ring of DEPTH entries {tag, data, done}; pointers wr/res/rd (log2 DEPTH bits, wrap modulo DEPTH); count 0..DEPTH.
- Reset: all pointers, counts, done bits, lock, rr_last and ERR cleared. ISSUE_READY=2'b11, WB_VALID=0, WB_PHASE=0, WB_TAG=0, WB_DATA=0.
- ISSUE_READY[p] = (count_p < DEPTH), from registered count only.
- Issue:
  - ISSUE_EN[p] & ISSUE_READY[p] writes the tag at wr_p, clears done, increments wr_p and count_p.
  - ISSUE_EN=2'b11: only phase 1 is enqueued (matches SF MO1 priority); ERR is set.
  - ISSUE_EN[p] with ISSUE_READY[p]=0: ignored; ERR is set.
- Result:
  - PHASE_EN[p] writes DIN (or its expansion) at res_p, sets done, increments res_p.
  - If no allocated, not-done entry exists (res_p==wr_p with done set, or count_p==0), the result is dropped and ERR is set.
  - PHASE_EN=2'b11 sets ERR; both phases are written if each is legal.
- Writeback:
  - head_p ready = count_p>0 & done[rd_p].
  - When not locked, select a ready head. If both are ready, choose the phase ≠ rr_last. Assert WB_VALID, set lock.
  - While locked, WB_PHASE/WB_TAG/WB_DATA are held stable, regardless of the other phase.
  - WB_VALID & WB_READY: pop (rd_p++, count_p--, clear done), update rr_last, release lock. The next selection is allowed in the same cycle.
  - WB_* are driven combinationally from registered entry state. A result strobed at cycle N is eligible at N+1, so the minimum latency is 1 cycle.
- Same-cycle events on one phase:
  - Issue + pop: count unchanged.
  - Issue + result + pop: all three apply independently.
  - Pop at count==DEPTH frees a credit that is visible the next cycle.
- ERR clears only on RST.
- Reset mid-operation: all state is discarded. Late results arriving after reset find count=0, are dropped, and set ERR.

Optional Feature:
- Macro: MTSP_SF_WB_EXPAND_EN.
- Defined: a stored result is expanded to IEEE-754 single precision:
  - sign → bit31
  - exp8 = (exp7==0) ? 0 : exp7+64 → bits[30:23]
  - frac16 → bits[22:7]
  - bits[6:0] = 0
- Undefined: DIN is stored and output unchanged (upper 8 bits zero).

Test Plan:
- Reset, then issue phase 0 tag 5; PHASE_EN=01, DIN=0x003F0000 three cycles later. Next cycle: WB_VALID=1, WB_PHASE=0, WB_TAG=5, WB_DATA=0x003F0000 (0x3F800000 with EXPAND_EN).
- Issue 4 ops on phase 1 with tags 1..4 and WB_READY=0. ISSUE_READY[1]=0 after the 4th; a 5th issue is ignored and ERR=1. Raise WB_READY: tags pop 1,2,3,4 in order and ISSUE_READY[1] returns to 1 the cycle after the first pop.
- Both heads ready, with tags 7 (phase 0) and 9 (phase 1), rr_last=0. Phase 1 is served first, then phase 0. WB_* stay stable across 3 cycles of WB_READY=0.
- PHASE_EN=10 with nothing outstanding: no WB_VALID, ERR=1.
- Expansion: DIN=0x003E8000 gives WB_DATA=0x3F400000 with EXPAND_EN. DIN=0x00800000 (exp 0, sign 1) gives 0x80000000.
- Assert RST with 2 ops outstanding: next cycle ISSUE_READY=11, WB_VALID=0, ERR=0. A late PHASE_EN=01 sets ERR=1.

Source files
------------

// File: rtl/mtsp_sf_wb_collector_if.sv
// Issue / result / writeback signal bundle for mtsp_sf_wb_collector.
// master = SF issue logic + RF write port side, slave = the collector.
interface mtsp_sf_wb_collector_if #(
  parameter int TAG_W = 6
);
  logic [1:0]       ISSUE_EN;
  logic [TAG_W-1:0] ISSUE_TAG0;
  logic [TAG_W-1:0] ISSUE_TAG1;
  logic [1:0]       ISSUE_READY;
  logic [1:0]       PHASE_EN;
  logic [31:0]      DIN;
  logic             WB_VALID;
  logic             WB_READY;
  logic             WB_PHASE;
  logic [TAG_W-1:0] WB_TAG;
  logic [31:0]      WB_DATA;
  logic             ERR;

  modport master (
    output ISSUE_EN, ISSUE_TAG0, ISSUE_TAG1, PHASE_EN, DIN, WB_READY,
    input  ISSUE_READY, WB_VALID, WB_PHASE, WB_TAG, WB_DATA, ERR
  );

  modport slave (
    input  ISSUE_EN, ISSUE_TAG0, ISSUE_TAG1, PHASE_EN, DIN, WB_READY,
    output ISSUE_READY, WB_VALID, WB_PHASE, WB_TAG, WB_DATA, ERR
  );
endinterface

// File: rtl/mtsp_sf_wb_collector.sv
// Writeback collector behind the SF reciprocal unit: per-phase credit rings, round-robin writeback.
// Optional macro MTSP_SF_WB_EXPAND_EN stores results expanded to IEEE-754 single precision.
module mtsp_sf_wb_collector #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                    CLK,
  input  logic                    RST,
  mtsp_sf_wb_collector_if.slave   bus,
  output logic                    o_dbg_lock
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  // WB handshake: WB_VALID stays high with WB_PHASE/TAG/DATA frozen until the cycle
  // WB_READY is seen high; that cycle pops the entry and releases the lock.

  logic [TAG_W-1:0] r_tag  [2][DEPTH];
  logic [31:0]      r_data [2][DEPTH];
  logic [DEPTH-1:0] r_done [2];
  ptr_t             r_wr   [2];
  ptr_t             r_res  [2];
  ptr_t             r_rd   [2];
  cnt_t             r_cnt  [2];
  cnt_t             r_ndone[2];
  logic             r_rr_last;
  logic             r_sel;
  logic             r_err;
  state_t           r_state;
  state_t           w_state_nxt;

  logic [TAG_W-1:0] w_itag[2];
  logic [1:0]       w_credit;
  logic [1:0]       w_slot;
  logic [1:0]       w_iss;
  logic [1:0]       w_res;
  logic [1:0]       w_head;
  logic [1:0]       w_pop;
  logic             w_iss_err;
  logic             w_res_err;
  logic             w_pick;
  logic             w_valid;
  logic             w_phase;

  function automatic logic [31:0] f_store(input logic [31:0] din);
`ifdef MTSP_SF_WB_EXPAND_EN
    logic [7:0] e8;
    e8 = (din[22:16] == 7'd0) ? 8'd0 : ({1'b0, din[22:16]} + 8'd64);
    return {din[23], e8, din[15:0], 7'd0};
`else
    return din;
`endif
  endfunction

  assign w_itag[0] = bus.ISSUE_TAG0;
  assign w_itag[1] = bus.ISSUE_TAG1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_credit[p] = (r_cnt[p] < cnt_t'(DEPTH));
      // a result needs an allocated entry that is still waiting for data
      w_slot[p]   = (r_ndone[p] < r_cnt[p]);
      w_head[p]   = (r_cnt[p] != '0) & r_done[p][r_rd[p]];
    end
  end

  always_comb begin
    w_iss     = 2'b00;
    w_iss_err = 1'b0;
    if (bus.ISSUE_EN == 2'b11) begin
      w_iss[1]  = w_credit[1];
      w_iss_err = 1'b1;
    end else begin
      w_iss     = bus.ISSUE_EN & w_credit;
      w_iss_err = |(bus.ISSUE_EN & ~w_credit);
    end
  end

  assign w_res     = bus.PHASE_EN & w_slot;
  assign w_res_err = (bus.PHASE_EN == 2'b11) | (|(bus.PHASE_EN & ~w_slot));
  assign w_pick    = (w_head == 2'b11) ? ~r_rr_last : w_head[1];

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_phase     = 1'b0;
    w_pop       = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (|w_head) begin
          w_valid = 1'b1;
          w_phase = w_pick;
          if (!bus.WB_READY) w_state_nxt = S_LOCK;
        end
      end
      S_LOCK: begin
        w_valid = 1'b1;
        w_phase = r_sel;
        if (bus.WB_READY) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_valid && bus.WB_READY) w_pop[w_phase] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int p = 0; p < 2; p++) begin
        r_done[p]  <= '0;
        r_wr[p]    <= '0;
        r_res[p]   <= '0;
        r_rd[p]    <= '0;
        r_cnt[p]   <= '0;
        r_ndone[p] <= '0;
      end
      r_rr_last <= 1'b0;
      r_sel     <= 1'b0;
      r_err     <= 1'b0;
      r_state   <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) r_sel <= w_phase;
      if (w_iss_err || w_res_err) r_err <= 1'b1;
      if (w_valid && bus.WB_READY) r_rr_last <= w_phase;
      // issue, pop and result touch distinct entries, so all three may land together
      for (int p = 0; p < 2; p++) begin
        if (w_iss[p]) begin
          r_tag[p][r_wr[p]]  <= w_itag[p];
          r_done[p][r_wr[p]] <= 1'b0;
          r_wr[p]            <= r_wr[p] + ptr_t'(1);
        end
        if (w_pop[p]) begin
          r_done[p][r_rd[p]] <= 1'b0;
          r_rd[p]            <= r_rd[p] + ptr_t'(1);
        end
        if (w_res[p]) begin
          r_data[p][r_res[p]] <= f_store(bus.DIN);
          r_done[p][r_res[p]] <= 1'b1;
          r_res[p]            <= r_res[p] + ptr_t'(1);
        end
        r_cnt[p]   <= r_cnt[p]   + cnt_t'(w_iss[p]) - cnt_t'(w_pop[p]);
        r_ndone[p] <= r_ndone[p] + cnt_t'(w_res[p]) - cnt_t'(w_pop[p]);
      end
    end
  end

  assign bus.ISSUE_READY = w_credit;
  assign bus.WB_VALID    = w_valid;
  assign bus.WB_PHASE    = w_phase;
  assign bus.WB_TAG      = w_valid ? r_tag[w_phase][r_rd[w_phase]]  : '0;
  assign bus.WB_DATA     = w_valid ? r_data[w_phase][r_rd[w_phase]] : '0;
  assign bus.ERR         = r_err;
  assign o_dbg_lock      = (r_state == S_LOCK);
endmodule

// File: tb/tb_mtsp_sf_wb_collector.sv
// Directed bench for mtsp_sf_wb_collector; writebacks checked against an expected queue.
module tb_mtsp_sf_wb_collector;
  localparam int TAG_W = 6;
  localparam int EW    = 1 + TAG_W + 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_lock;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  mtsp_sf_wb_collector_if #(.TAG_W(TAG_W)) bus ();

  mtsp_sf_wb_collector #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .o_dbg_lock(dbg_lock)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_data(input logic [31:0] din);
`ifdef MTSP_SF_WB_EXPAND_EN
    logic [7:0] e8;
    e8 = (din[22:16] == 7'd0) ? 8'd0 : (8'(din[22:16]) + 8'd64);
    return {din[23], e8, din[15:0], 7'd0};
`else
    return din;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input logic ph, input logic [TAG_W-1:0] tag);
    bus.ISSUE_EN   = ph ? 2'b10 : 2'b01;
    bus.ISSUE_TAG0 = tag;
    bus.ISSUE_TAG1 = tag;
    step();
    bus.ISSUE_EN = 2'b00;
  endtask

  task automatic result(input logic ph, input logic [TAG_W-1:0] tag, input logic [31:0] din);
    bus.PHASE_EN = ph ? 2'b10 : 2'b01;
    bus.DIN      = din;
    exp_q.push_back({ph, tag, model_data(din)});
    step();
    bus.PHASE_EN = 2'b00;
  endtask

  // scoreboard: every accepted writeback must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && bus.WB_VALID === 1'b1 && bus.WB_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 64'(bus.WB_TAG), 64'hFFFF);
      end else begin
        chk("wb_entry", 64'({bus.WB_PHASE, bus.WB_TAG, bus.WB_DATA}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bus.ISSUE_EN = 2'b00; bus.ISSUE_TAG0 = '0; bus.ISSUE_TAG1 = '0;
    bus.PHASE_EN = 2'b00; bus.DIN = '0; bus.WB_READY = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_issue_ready", 64'(bus.ISSUE_READY), 64'h3);
    chk("rst_wb_valid",    64'(bus.WB_VALID),    64'h0);
    chk("rst_wb_phase",    64'(bus.WB_PHASE),    64'h0);
    chk("rst_wb_tag",      64'(bus.WB_TAG),      64'h0);
    chk("rst_wb_data",     64'(bus.WB_DATA),     64'h0);
    chk("rst_err",         64'(bus.ERR),         64'h0);

    // single op on phase 0, result three cycles after issue
    issue(1'b0, 6'd5);
    step(); step();
    result(1'b0, 6'd5, 32'h003F0000);
    chk("t1_valid", 64'(bus.WB_VALID), 64'h1);
    chk("t1_phase", 64'(bus.WB_PHASE), 64'h0);
    chk("t1_tag",   64'(bus.WB_TAG),   64'h5);
`ifdef MTSP_SF_WB_EXPAND_EN
    chk("t1_data",  64'(bus.WB_DATA),  64'h3F800000);
`else
    chk("t1_data",  64'(bus.WB_DATA),  64'h003F0000);
`endif
    bus.WB_READY = 1'b1;
    step();
    bus.WB_READY = 1'b0;
    chk("t1_drained", 64'(bus.WB_VALID), 64'h0);
    chk("t1_err",     64'(bus.ERR),      64'h0);

    // fill phase 1 to DEPTH, overflow issue, drain in order
    do_reset();
    for (int i = 1; i <= 4; i++) issue(1'b1, 6'(i));
    chk("t2_full_ready", 64'(bus.ISSUE_READY), 64'h1);
    chk("t2_full_err",   64'(bus.ERR),         64'h0);
    issue(1'b1, 6'd5);
    chk("t2_ovf_err",    64'(bus.ERR),         64'h1);
    chk("t2_ovf_ready",  64'(bus.ISSUE_READY), 64'h1);
    for (int i = 1; i <= 4; i++) result(1'b1, 6'(i), 32'h00100000 + 32'(i * 32'h1111));
    chk("t2_head_tag",   64'(bus.WB_TAG),      64'h1);
    bus.WB_READY = 1'b1;
    step();
    chk("t2_credit_back", 64'(bus.ISSUE_READY), 64'h3);
    step(); step(); step();
    bus.WB_READY = 1'b0;
    chk("t2_empty_valid", 64'(bus.WB_VALID), 64'h0);
    chk("t2_err_sticky",  64'(bus.ERR),      64'h1);

    // both heads ready together: phase 1 first, held while not ready
    do_reset();
    issue(1'b0, 6'd7);
    issue(1'b1, 6'd9);
    bus.PHASE_EN = 2'b11;
    bus.DIN      = 32'h003F4000;
    exp_q.push_back({1'b1, 6'd9, model_data(32'h003F4000)});
    exp_q.push_back({1'b0, 6'd7, model_data(32'h003F4000)});
    step();
    bus.PHASE_EN = 2'b00;
    chk("t3_err_dual", 64'(bus.ERR), 64'h1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", 64'(bus.WB_VALID), 64'h1);
      chk("t3_hold_phase", 64'(bus.WB_PHASE), 64'h1);
      chk("t3_hold_tag",   64'(bus.WB_TAG),   64'h9);
      chk("t3_hold_data",  64'(bus.WB_DATA),  64'(model_data(32'h003F4000)));
      step();
    end
    bus.WB_READY = 1'b1;
    step();
    chk("t3_second_phase", 64'(bus.WB_PHASE), 64'h0);
    chk("t3_second_tag",   64'(bus.WB_TAG),   64'h7);
    step();
    bus.WB_READY = 1'b0;
    chk("t3_done_valid", 64'(bus.WB_VALID), 64'h0);

    // result with nothing outstanding
    do_reset();
    bus.PHASE_EN = 2'b10;
    bus.DIN      = 32'h003F0000;
    step();
    bus.PHASE_EN = 2'b00;
    chk("t4_valid", 64'(bus.WB_VALID), 64'h0);
    chk("t4_err",   64'(bus.ERR),      64'h1);
    step();
    chk("t4_valid_later", 64'(bus.WB_VALID), 64'h0);

    // expansion corner values
    do_reset();
    issue(1'b0, 6'd3);
    issue(1'b0, 6'd4);
    result(1'b0, 6'd3, 32'h003E8000);
`ifdef MTSP_SF_WB_EXPAND_EN
    chk("t5_data_a", 64'(bus.WB_DATA), 64'h3F400000);
`else
    chk("t5_data_a", 64'(bus.WB_DATA), 64'h003E8000);
`endif
    result(1'b0, 6'd4, 32'h00800000);
    bus.WB_READY = 1'b1;
    step();
`ifdef MTSP_SF_WB_EXPAND_EN
    chk("t5_data_b", 64'(bus.WB_DATA), 64'h80000000);
`else
    chk("t5_data_b", 64'(bus.WB_DATA), 64'h00800000);
`endif
    step();
    bus.WB_READY = 1'b0;
    chk("t5_err", 64'(bus.ERR), 64'h0);

    // reset with ops in flight, then a late result
    do_reset();
    issue(1'b0, 6'd1);
    issue(1'b0, 6'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_issue_ready", 64'(bus.ISSUE_READY), 64'h3);
    chk("t6_valid",       64'(bus.WB_VALID),    64'h0);
    chk("t6_err",         64'(bus.ERR),         64'h0);
    bus.PHASE_EN = 2'b01;
    bus.DIN      = 32'h003F0000;
    step();
    bus.PHASE_EN = 2'b00;
    chk("t6_late_err",   64'(bus.ERR),      64'h1);
    chk("t6_late_valid", 64'(bus.WB_VALID), 64'h0);

    step();
    chk("sb_leftover", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
